adc_scan_sequencer: RTL and testbench
=====================================

Name: adc_scan_sequencer

Overview:
Sequences the MCP3008 8-channel 10-bit SPI ADC, replacing inline bit-banged scan logic in motor-control top levels. Round-robins over enabled channels (accel, current, battery). Accepts one-shot priority conversion requests from other blocks and arbitrates them ahead of the scan. Emits each result with its channel number as a single-cycle valid strobe.

Parameters:
SCLK_HALF, 1350, clk cycles per SCLK half-period (50 MHz / 2700 ≈ 18.5 kHz, same as the existing controlCLK).
CS_IDLE_PERIODS, 1, SCLK periods that CS is held high between frames (≥1).
DEFAULT_MASK, 8'hFF, channel mask used while ch_mask_ovr is low.

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous, active-high reset
enable  input  1  scan enable; frames start only while high
ch_mask_ovr  input  1  1: use ch_mask; 0: use DEFAULT_MASK
ch_mask  input  8  per-channel scan enable, bit n = CHn
req_valid  input  1  priority conversion request
req_ch  input  3  channel for the priority request
req_ready  output  1  request slot free
AD_CLK  output  1  SPI SCLK to MCP3008
CS  output  1  MCP3008 chip select, active low
DIN  output  1  MCP3008 command input
DOUT  input  1  MCP3008 data output
result_valid  output  1  one-cycle strobe, result_* valid
result_ch  output  3  channel of this result
result_data  output  10  conversion result, MSB first as received
busy  output  1  high from CS fall to CS rise

Behaviour:
- Reset values: AD_CLK=0, CS=1, DIN=0, result_valid=0, result_ch=0, result_data=0, busy=0, req_ready=1. Round-robin pointer=0, request slot empty, state=IDLE.
- Async reset mid-frame: CS goes high immediately; no result is emitted for the partial frame.
- SCLK timing: divider produces rise/fall strobes every SCLK_HALF clk cycles. AD_CLK toggles only in frame states and idles low.
- DIN changes only on SCLK fall or CS fall. DOUT is sampled on the clk following each SCLK rise.
- States and transitions:
  - IDLE → SELECT when a frame start is allowed.
  - SELECT (1 clk): choose channel, drive CS=0 and DIN=1 (start bit).
  - CMD (5 SCLK periods): bits are start=1, SGL=1, D2, D1, D0.
  - SAMPLE (2 SCLK periods): sample window plus null bit; DIN=0.
  - DATA (10 SCLK periods): shift DOUT into bit 9 first.
  - DONE (1 clk): result_valid=1; CS=1.
  - GAP (CS_IDLE_PERIODS SCLK periods, CS high) → IDLE.
- Frame: 17 SCLK periods with CS low. result_valid asserts exactly 1 clk after the 10th DATA sample.
- Frame start: allowed in IDLE if enable=1 and (slot full or effective mask ≠ 0). Otherwise stay in IDLE with CS=1.
- Arbitration:
  - A full request slot always wins at SELECT.
  - Otherwise take the next set mask bit at or after the pointer, wrapping 7→0. The pointer then moves to that channel+1 (mod 8).
  - Priority frames do not move the pointer.
  - Mask changes take effect at the next SELECT.
- Request handshake:
  - Accepted when req_valid & req_ready; req_ch is latched and req_ready drops next clk.
  - Slot clears and req_ready rises in the DONE cycle of the frame that served it.
  - A request is accepted even while enable=0 but is served only once enable=1.
  - A request that arrives on the SELECT clk waits for the next frame.
- enable deasserted mid-frame: the current frame completes, including DONE and GAP.
- Simultaneous slot-full and empty mask: the priority frame runs, then the block idles.

Optional Feature:
Macro ADC_REGFILE_EN.
- Defined: adds output scan_data [79:0], where scan_data[10n+9:10n] is the latest result for CHn. Written in the DONE cycle, reset to 0.
- Undefined: no register file and no scan_data port; results are available only via the result_* strobe.

Decomposition:
- Package adc_scan_pkg holds:
  - enum state_t {IDLE, SELECT, CMD, SAMPLE, DATA, DONE, GAP};
  - typedef ch_t logic[2:0];
  - typedef adc_word_t logic[9:0];
  - localparams CMD_BITS=5, SAMPLE_BITS=2, DATA_BITS=10.
- One sub-module, adc_sclk_gen: divider plus rise/fall strobes, reset to the SCLK-low phase.

Test Plan:
- Reset → CS=1, AD_CLK=0, req_ready=1.
- enable=1, mask 8'hFF, DOUT model returns 10'h155 for CH3 → result_ch sequence 0,1,2,…,7,0; CH3 result_data=10'h155. Each valid falls 1 clk after the 10th sample; CS low for exactly 17 SCLK periods.
- mask 8'b0010_0100 → results alternate CH2, CH5. On the DIN trace, CH5 command bits are 1,1,1,0,1.
- During a CH2 frame, req_valid with req_ch=6 → req_ready low next clk. Next frame is CH6, then the scan resumes at CH5 (pointer unchanged). req_ready returns high at CH6's DONE.
- Drop enable mid-DATA → that frame still yields a result, then CS stays high. Set mask=0 with enable=1 → no frames.
- Assert rst during the CMD bits → CS rises asynchronously and no result_valid is emitted. After release, scan restarts at CH0.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// rtl/adc_scan_pkg.sv - shared types, frame lengths and round-robin pick for the MCP3008 scan sequencer
package adc_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        CMD,
        SAMPLE,
        DATA,
        DONE,
        GAP
    } state_t;

    typedef logic [2:0] ch_t;
    typedef logic [9:0] adc_word_t;

    localparam int CMD_BITS    = 5;
    localparam int SAMPLE_BITS = 2;
    localparam int DATA_BITS   = 10;

    // Returns {found, channel}: first set mask bit at or after ptr, wrapping 7 -> 0.
    function automatic logic [3:0] next_channel(input logic [7:0] mask, input ch_t ptr);
        logic [3:0] pick;
        ch_t        idx;
        pick = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (mask[idx]) begin
                pick = {1'b1, idx};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// rtl/adc_sclk_gen.sv - SCLK divider with rise/fall strobes, held in the low phase while not running
module adc_sclk_gen #(
    parameter int HALF = 1350
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt;
    logic          term;

    // Strobes mark the clk edge on which sclk is about to toggle.
    assign term = run && (cnt == CW'(HALF - 1));
    assign rise = term && !sclk;
    assign fall = term && sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!run) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (term) begin
            cnt  <= '0;
            sclk <= !sclk;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - MCP3008 round-robin scan with priority request slot; ADC_REGFILE_EN adds scan_data
module adc_scan_sequencer
    import adc_scan_pkg::*;
#(
    parameter int         SCLK_HALF       = 1350,
    parameter int         CS_IDLE_PERIODS = 1,
    parameter logic [7:0] DEFAULT_MASK    = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       ch_mask_ovr,
    input  logic [7:0] ch_mask,
    input  logic       req_valid,
    input  logic [2:0] req_ch,
    output logic       req_ready,
    output logic       AD_CLK,
    output logic       CS,
    output logic       DIN,
    input  logic       DOUT,
    output logic       result_valid,
    output logic [2:0] result_ch,
    output logic [9:0] result_data,
    output logic       busy
`ifdef ADC_REGFILE_EN
    ,
    output logic [79:0] scan_data
`endif
);

    state_t     state;
    state_t     state_nxt;

    logic       sclk;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       sclk_run;
    logic       rise_q;

    logic [3:0] bit_cnt;
    ch_t        cur_ch;
    logic       prio;
    ch_t        ptr;
    logic       slot_full;
    ch_t        slot_ch;
    logic [8:0] shift_q;
    ch_t        res_ch_q;
    adc_word_t  res_data_q;

    logic [7:0] eff_mask;
    logic       scan_found;
    ch_t        scan_ch;
    logic       frame_start;
    logic [4:0] cmd_word;
    logic [2:0] cmd_sel;

    assign eff_mask                = ch_mask_ovr ? ch_mask : DEFAULT_MASK;
    assign {scan_found, scan_ch}   = next_channel(eff_mask, ptr);
    assign frame_start             = enable && (slot_full || scan_found);
    assign cmd_word                = {2'b11, cur_ch};
    assign cmd_sel                 = 3'(CMD_BITS - 1) - bit_cnt[2:0];
    assign req_ready               = !slot_full;
    assign result_ch               = res_ch_q;
    assign result_data             = res_data_q;

    // GAP keeps the divider running so CS-high time is measured in SCLK periods.
    assign sclk_run = (state == CMD) || (state == SAMPLE) || (state == DATA) || (state == GAP);

    adc_sclk_gen #(
        .HALF(SCLK_HALF)
    ) u_sclk_gen (
        .clk (clk),
        .rst (rst),
        .run (sclk_run),
        .sclk(sclk),
        .rise(sclk_rise),
        .fall(sclk_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        CS           = 1'b1;
        DIN          = 1'b0;
        AD_CLK       = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = SELECT;
                end
            end
            SELECT: begin
                CS        = 1'b0;
                busy      = 1'b1;
                DIN       = 1'b1;
                state_nxt = CMD;
            end
            CMD: begin
                CS     = 1'b0;
                busy   = 1'b1;
                AD_CLK = sclk;
                DIN    = cmd_word[cmd_sel];
                if (sclk_fall && (bit_cnt == 4'(CMD_BITS - 1))) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                CS     = 1'b0;
                busy   = 1'b1;
                AD_CLK = sclk;
                if (sclk_fall && (bit_cnt == 4'(SAMPLE_BITS - 1))) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                CS     = 1'b0;
                busy   = 1'b1;
                AD_CLK = sclk;
                if (rise_q && (bit_cnt == 4'(DATA_BITS - 1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                state_nxt    = GAP;
            end
            GAP: begin
                if (sclk_fall && (bit_cnt == 4'(CS_IDLE_PERIODS - 1))) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q     <= 1'b0;
            bit_cnt    <= '0;
            cur_ch     <= '0;
            prio       <= 1'b0;
            ptr        <= '0;
            slot_full  <= 1'b0;
            slot_ch    <= '0;
            shift_q    <= '0;
            res_ch_q   <= '0;
            res_data_q <= '0;
        end else begin
            rise_q <= sclk_rise;

            // CMD/SAMPLE/GAP count SCLK falls; DATA counts DOUT samples.
            if (state_nxt != state) begin
                bit_cnt <= '0;
            end else if ((state == DATA) ? rise_q : sclk_fall) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if ((state == IDLE) && (state_nxt == SELECT)) begin
                if (slot_full) begin
                    cur_ch <= slot_ch;
                    prio   <= 1'b1;
                end else begin
                    cur_ch <= scan_ch;
                    prio   <= 1'b0;
                    ptr    <= scan_ch + 3'd1;
                end
            end

            if ((state == DATA) && rise_q) begin
                shift_q <= {shift_q[7:0], DOUT};
            end

            if ((state == DATA) && (state_nxt == DONE)) begin
                res_ch_q   <= cur_ch;
                res_data_q <= {shift_q, DOUT};
            end

            if (req_valid && req_ready) begin
                slot_full <= 1'b1;
                slot_ch   <= req_ch;
            end else if ((state == DATA) && (state_nxt == DONE) && prio) begin
                slot_full <= 1'b0;
            end
        end
    end

`ifdef ADC_REGFILE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_data <= '0;
        end else if (state == DONE) begin
            scan_data[int'(res_ch_q) * 10 +: 10] <= res_data_q;
        end
    end
`endif

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - randomized bench for adc_scan_sequencer with an MCP3008 device model
module tb_adc_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       ch_mask_ovr;
    logic [7:0] ch_mask;
    logic       req_valid;
    logic [2:0] req_ch;
    logic       req_ready;
    logic       AD_CLK;
    logic       CS;
    logic       DIN;
    logic       DOUT;
    logic       result_valid;
    logic [2:0] result_ch;
    logic [9:0] result_data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] adc_val [8];

    // device-model / monitor state
    int         mon_rises = 0;
    int         since_rise = 0;
    int         frames_started = 0;
    logic       ad_prev = 1'b0;
    logic       cs_prev = 1'b1;
    logic [4:0] din_bits = '0;
    logic [2:0] dec_ch = '0;
    logic [9:0] word;

    int         res_count = 0;
    int         res_ch;
    int         res_data;
    int         res_rises;
    int         res_lat;
    int         res_din;
    int         res_ready;

    // reference model state
    int m_ptr = 0;
    bit m_slot_full = 0;
    int m_slot_ch = 0;

    adc_scan_sequencer #(
        .SCLK_HALF      (4),
        .CS_IDLE_PERIODS(1),
        .DEFAULT_MASK   (8'hFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .ch_mask_ovr (ch_mask_ovr),
        .ch_mask     (ch_mask),
        .req_valid   (req_valid),
        .req_ch      (req_ch),
        .req_ready   (req_ready),
        .AD_CLK      (AD_CLK),
        .CS          (CS),
        .DIN         (DIN),
        .DOUT        (DOUT),
        .result_valid(result_valid),
        .result_ch   (result_ch),
        .result_data (result_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // MCP3008 model: decodes the command on SCLK rises, shifts data out on SCLK falls.
    always @(negedge clk) begin
        if (rst) begin
            mon_rises  = 0;
            since_rise = 0;
            ad_prev    = 1'b0;
            cs_prev    = 1'b1;
            DOUT       = 1'b0;
        end else begin
            if (cs_prev && !CS) begin
                mon_rises = 0;
                din_bits  = '0;
                frames_started++;
            end
            if (!ad_prev && AD_CLK) begin
                mon_rises++;
                since_rise = 0;
                if (mon_rises <= 5) din_bits = {din_bits[3:0], DIN};
            end else begin
                since_rise++;
            end
            if (ad_prev && !AD_CLK && !CS) begin
                if (mon_rises == 5) dec_ch = din_bits[2:0];
                word = adc_val[dec_ch];
                if (mon_rises >= 7 && mon_rises <= 16) DOUT = word[4'(16 - mon_rises)];
                else DOUT = 1'b0;
            end
            if (result_valid) begin
                res_ch    = int'(result_ch);
                res_data  = int'(result_data);
                res_rises = mon_rises;
                res_lat   = since_rise;
                res_din   = int'(din_bits);
                res_ready = int'(req_ready);
                res_count++;
            end
            ad_prev = AD_CLK;
            cs_prev = CS;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic model_pick(output int ch, output bit prio);
        logic [7:0] m;
        m = ch_mask_ovr ? ch_mask : 8'hFF;
        if (m_slot_full) begin
            ch   = m_slot_ch;
            prio = 1;
        end else begin
            prio = 0;
            ch   = -1;
            for (int i = 0; i < 8; i++) begin
                if (ch < 0 && m[(m_ptr + i) % 8]) ch = (m_ptr + i) % 8;
            end
            m_ptr = (ch + 1) % 8;
        end
    endtask

    task automatic issue_req(input int c);
        req_ch    = 3'(c);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("req_ready_drop", int'(req_ready), 0);
        m_slot_full = 1;
        m_slot_ch   = c;
    endtask

    task automatic wait_cs_low();
        int n = 0;
        while (CS && n < 3000) begin
            tick();
            n++;
        end
        chk("cs_fall_timeout", int'(CS), 0);
    endtask

    task automatic expect_result(input int last, input int ec, input bit ep);
        int n = 0;
        while (res_count == last && n < 3000) begin
            tick();
            n++;
        end
        chk("result_seen", res_count, last + 1);
        if (res_count != last) begin
            chk("res_ch", res_ch, ec);
            chk("res_data", res_data, int'(adc_val[ec]));
            chk("cs_low_sclk_periods", res_rises, 17);
            chk("valid_after_sample", res_lat, 1);
            chk("din_cmd", res_din, 24 + ec);
            if (ep) m_slot_full = 0;
            chk("req_ready_at_done", res_ready, int'(!m_slot_full));
            tick();
            chk("valid_pulse", int'(result_valid), 0);
        end
    endtask

    task automatic run_frame(input bit mid_req, input int rch, input int dly);
        int ec;
        bit ep;
        int last;
        last = res_count;
        model_pick(ec, ep);
        if (mid_req) begin
            wait_cs_low();
            repeat (dly) tick();
            issue_req(rch);
        end
        expect_result(last, ec, ep);
    endtask

    initial begin
        int f0;
        int n;
        int last;
        int ec;
        bit ep;
        int mode;

        for (int i = 0; i < 8; i++) adc_val[i] = 10'($urandom_range(0, 1023));
        adc_val[3] = 10'h155;

        rst         = 1'b1;
        enable      = 1'b0;
        ch_mask_ovr = 1'b0;
        ch_mask     = 8'h00;
        req_valid   = 1'b0;
        req_ch      = 3'd0;
        repeat (3) tick();
        chk("rst_cs", int'(CS), 1);
        chk("rst_ad_clk", int'(AD_CLK), 0);
        chk("rst_din", int'(DIN), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_result_valid", int'(result_valid), 0);
        chk("rst_result_ch", int'(result_ch), 0);
        chk("rst_result_data", int'(result_data), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick();

        // default mask: 0..7 then wrap to 0
        enable = 1'b1;
        for (int k = 0; k < 9; k++) run_frame(0, 0, 0);

        // sparse mask alternates CH2 / CH5
        ch_mask_ovr = 1'b1;
        ch_mask     = 8'b0010_0100;
        run_frame(0, 0, 0);
        run_frame(0, 0, 0);
        // request raised on the SELECT clk of a CH2 frame waits for the next frame
        run_frame(1, 6, 0);
        run_frame(0, 0, 0);
        run_frame(0, 0, 0);

        for (int k = 0; k < 24; k++) begin
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                ch_mask_ovr = 1'($urandom_range(0, 1));
                ch_mask     = 8'($urandom_range(1, 255));
            end
            if (mode == 1 && !m_slot_full) issue_req($urandom_range(0, 7));
            run_frame(mode == 2 && !m_slot_full, $urandom_range(0, 7), $urandom_range(0, 100));
        end

        // enable dropped mid-DATA: frame completes, then no more frames
        last = res_count;
        model_pick(ec, ep);
        wait_cs_low();
        n = 0;
        while (mon_rises < 9 && n < 500) begin
            tick();
            n++;
        end
        chk("reach_data_phase", int'(mon_rises >= 9), 1);
        enable = 1'b0;
        expect_result(last, ec, ep);
        f0 = frames_started;
        repeat (300) tick();
        chk("no_frame_enable_low", frames_started - f0, 0);
        chk("cs_idle_high", int'(CS), 1);

        // request accepted while disabled, served once enabled even with an empty mask
        issue_req(4);
        repeat (100) tick();
        chk("req_held_disabled", frames_started - f0, 0);
        ch_mask_ovr = 1'b1;
        ch_mask     = 8'h00;
        enable      = 1'b1;
        run_frame(0, 0, 0);
        f0 = frames_started;
        repeat (300) tick();
        chk("no_frame_mask_zero", frames_started - f0, 0);

        // async reset during the command bits
        ch_mask_ovr = 1'b0;
        wait_cs_low();
        n = 0;
        while (mon_rises < 2 && n < 500) begin
            tick();
            n++;
        end
        last = res_count;
        #2;
        rst = 1'b1;
        #1;
        chk("cs_async_rst", int'(CS), 1);
        chk("busy_async_rst", int'(busy), 0);
        repeat (3) begin
            tick();
            chk("no_valid_in_rst", int'(result_valid), 0);
        end
        rst = 1'b0;
        chk("no_partial_result", res_count, last);
        m_ptr       = 0;
        m_slot_full = 0;
        run_frame(0, 0, 0);
        run_frame(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
